bus_mailbox: RTL and testbench

BUS_MAILBOX -- requirements
Module: bus_mailbox

---
 rtl/bus_mailbox.sv | 176 +++++++++++++++++
 tb/tb_bus_mailbox.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_mailbox.sv
// Purpose : byte mailbox between a CPU bus window (4 registers at BASE) and a
//           pair of valid/ready byte streams, each side buffered by a FIFO.
// Latency : CPU reads are combinational; pushes and pops land on the next rising edge.
// Backpr. : tx_valid marks a non-empty TX FIFO. rx_ready drops when the RX FIFO is full.
//           A CPU write to a full TX FIFO is dropped and raises tx_ovf.
//           An rx_valid beat that arrives while RX is full is dropped and raises rx_ovf.
// Ports   : clk/rst (async active-low); databus/addrbus/rw CPU bus;
//           tx_data/tx_valid/tx_ready outbound stream; rx_data/rx_valid/rx_ready inbound stream.

// Generic byte FIFO. Storage is not reset. head reads 8'h00 while empty.
// A push while full and a pop while empty are both ignored.
module mailbox_fifo #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? 8'h00 : mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

module bus_mailbox #(
  parameter logic [15:0] BASE  = 16'hFF00,
  parameter int          DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire  [7:0]  databus,
  input  logic [15:0] addrbus,
  input  logic        rw,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          sel;
  logic [1:0]    reg_idx;
  logic          new_acc;
  logic          last_sel;
  logic [15:0]   last_addr;
  logic          last_rw;
  logic          tx_ovf;
  logic          rx_ovf;
  logic [7:0]    rd_dat;

  logic          tx_push;
  logic          tx_pop;
  logic          tx_full;
  logic          tx_empty;
  logic [CW-1:0] tx_count;
  logic          rx_pop;
  logic          rx_full;
  logic          rx_empty;
  logic [CW-1:0] rx_count;
  logic [7:0]    rx_head;
  logic          sts_w1c;

  // Widen the decode by one bit so that a BASE near the top of the map cannot wrap.
  assign sel     = ({1'b0, addrbus} >= {1'b0, BASE}) &&
                   ({1'b0, addrbus} <= ({1'b0, BASE} + 17'd3));
  assign reg_idx = addrbus[1:0] - BASE[1:0];

  // Side effects fire only on the first edge of a contiguous access.
  assign new_acc = sel && !(last_sel && (addrbus == last_addr) && (rw == last_rw));

  assign tx_push = new_acc && rw && (reg_idx == 2'd0);
  assign tx_pop  = tx_valid && tx_ready;
  assign rx_pop  = new_acc && !rw && (reg_idx == 2'd1);
  assign sts_w1c = new_acc && rw && (reg_idx == 2'd2);

  mailbox_fifo #(.DEPTH(DEPTH), .CW(CW)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .din   (databus),
    .pop   (tx_pop),
    .head  (tx_data),
    .count (tx_count),
    .full  (tx_full),
    .empty (tx_empty)
  );

  mailbox_fifo #(.DEPTH(DEPTH), .CW(CW)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_valid),
    .din   (rx_data),
    .pop   (rx_pop),
    .head  (rx_head),
    .count (rx_count),
    .full  (rx_full),
    .empty (rx_empty)
  );

  assign tx_valid = !tx_empty;
  assign rx_ready = !rx_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_sel  <= 1'b0;
      last_addr <= '0;
      last_rw   <= 1'b0;
      tx_ovf    <= 1'b0;
      rx_ovf    <= 1'b0;
    end else begin
      last_sel  <= sel;
      last_addr <= addrbus;
      last_rw   <= rw;
      // tx_full is judged before this edge, so a same-edge external pop cannot make room.
      // A set event wins over a coincident write-1-to-clear.
      if (tx_push && tx_full)              tx_ovf <= 1'b1;
      else if (sts_w1c && databus[2])      tx_ovf <= 1'b0;
      if (rx_valid && rx_full)             rx_ovf <= 1'b1;
      else if (sts_w1c && databus[3])      rx_ovf <= 1'b0;
    end
  end

  function automatic logic [3:0] sat4(input logic [CW-1:0] c);
    logic [4:0] e;
    e = 5'(c);
    return (e > 5'd15) ? 4'hF : e[3:0];
  endfunction

  always_comb begin
    rd_dat = 8'h00;
    case (reg_idx)
      2'd0:    rd_dat = 8'h00;
      2'd1:    rd_dat = rx_head;
      2'd2:    rd_dat = {4'b0000, rx_ovf, tx_ovf, !rx_empty, tx_full};
      default: rd_dat = {sat4(rx_count), sat4(tx_count)};
    endcase
  end

  // The bus is released while reset is held, even when a read is still addressed.
  assign databus = (rst && sel && !rw) ? rd_dat : 8'hzz;
endmodule

// File: tb/tb_bus_mailbox.sv
// Purpose : directed bench for bus_mailbox (BASE=FF00, DEPTH=8).
// Latency : CPU reads are sampled 1 time unit after addressing; state is sampled 1 time unit after an edge.
// Backpr. : tx_ready and rx_valid are driven directly by the stimulus.
// databus is a pulled-up net, so a released bus reads 8'hFF.
module tb_bus_mailbox;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  tri1  [7:0]  databus;
  logic [15:0] addrbus;
  logic        rw;
  logic        cpu_drv;
  logic [7:0]  cpu_dat;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  assign databus = cpu_drv ? cpu_dat : 8'hzz;

  bus_mailbox #(.BASE(16'hFF00), .DEPTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .databus  (databus),
    .addrbus  (addrbus),
    .rw       (rw),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    addrbus = 16'h0000;
    rw      = 1'b0;
    cpu_drv = 1'b0;
    cpu_dat = 8'h00;
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d, input int n);
    addrbus = a;
    rw      = 1'b1;
    cpu_drv = 1'b1;
    cpu_dat = d;
    repeat (n) tick();
    idle();
    tick();
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a, input int n, input logic [7:0] exp);
    logic [7:0] d;
    addrbus = a;
    rw      = 1'b0;
    cpu_drv = 1'b0;
    #1 d = databus;
    check(tag, d, exp);
    repeat (n) tick();
    idle();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    // Reset with a selected read present: the bus must stay released.
    addrbus = 16'hFF02;
    repeat (2) tick();
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_rx_ready", rx_ready, 1);
    check("rst_bus_hiz", databus, 8'hFF);
    idle();
    rst = 1'b1;
    tick();

    // A write held for 3 cycles pushes once.
    cpu_wr(16'hFF00, 8'hA5, 3);
    check("single_tx_valid", tx_valid, 1);
    check("single_tx_data", tx_data, 8'hA5);
    rd_chk("single_count", 16'hFF03, 1, 8'h01);

    // Eight more writes: 7 fit, the 9th overall overflows.
    for (int i = 0; i < 8; i++) cpu_wr(16'hFF00, 8'h10 + 8'(i), 1);
    rd_chk("full_count", 16'hFF03, 1, 8'h08);
    rd_chk("full_status", 16'hFF02, 1, 8'h05);
    check("full_head", tx_data, 8'hA5);
    cpu_wr(16'hFF02, 8'h04, 1);
    rd_chk("w1c_status", 16'hFF02, 1, 8'h01);

    // Full TX: the external pop and the CPU write share an edge, so the write is dropped.
    addrbus = 16'hFF00; rw = 1'b1; cpu_drv = 1'b1; cpu_dat = 8'hEE; tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    idle();
    tick();
    rd_chk("fullpop_count", 16'hFF03, 1, 8'h07);
    rd_chk("fullpop_status", 16'hFF02, 1, 8'h04);
    check("fullpop_head", tx_data, 8'h10);

    tx_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      check("drain_tx_data", tx_data, 8'h10 + 8'(i));
      tick();
    end
    tx_ready = 1'b0;
    check("drained_tx_valid", tx_valid, 0);
    check("drained_tx_data", tx_data, 8'h00);
    cpu_wr(16'hFF02, 8'h04, 1);
    rd_chk("clear_status", 16'hFF02, 1, 8'h00);

    // Push and pop on the same edge leave the count unchanged.
    cpu_wr(16'hFF00, 8'h5A, 1);
    addrbus = 16'hFF00; rw = 1'b1; cpu_drv = 1'b1; cpu_dat = 8'h6B; tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    idle();
    tick();
    rd_chk("pushpop_count", 16'hFF03, 1, 8'h01);
    check("pushpop_head", tx_data, 8'h6B);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    check("pushpop_empty", tx_valid, 0);

    // RX path: a read held for 2 cycles pops once; an empty read returns 00.
    rx_valid = 1'b1; rx_data = 8'h11;
    tick();
    rx_data = 8'h22;
    tick();
    rx_valid = 1'b0;
    rd_chk("rx_rd1", 16'hFF01, 2, 8'h11);
    rd_chk("rx_status1", 16'hFF02, 1, 8'h02);
    rd_chk("rx_count1", 16'hFF03, 1, 8'h10);
    rd_chk("rx_rd2", 16'hFF01, 1, 8'h22);
    rd_chk("rx_count0", 16'hFF03, 1, 8'h00);
    rd_chk("rx_rd_empty", 16'hFF01, 1, 8'h00);
    rd_chk("rx_empty_count", 16'hFF03, 1, 8'h00);
    rd_chk("rx_empty_status", 16'hFF02, 1, 8'h00);

    // RX overflow. A W1C that coincides with a new overflow leaves the flag set.
    rx_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      rx_data = 8'h80 + 8'(i);
      tick();
    end
    check("rx_full_ready", rx_ready, 0);
    rd_chk("rx_ovf_status", 16'hFF02, 1, 8'h0A);
    cpu_wr(16'hFF02, 8'h08, 1);
    rd_chk("rx_ovf_sticky", 16'hFF02, 1, 8'h0A);
    rx_valid = 1'b0;
    cpu_wr(16'hFF02, 8'h08, 1);
    rd_chk("rx_ovf_clear", 16'hFF02, 1, 8'h02);
    rd_chk("rx_full_count", 16'hFF03, 1, 8'h80);
    for (int i = 0; i < 5; i++) rd_chk("rx_drain", 16'hFF01, 1, 8'h80 + 8'(i));
    rd_chk("rx_count3", 16'hFF03, 1, 8'h30);

    // Reset in the middle of an RXDATA read.
    addrbus = 16'hFF01; rw = 1'b0; cpu_drv = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check("midrst_bus_hiz", databus, 8'hFF);
    check("midrst_rx_ready", rx_ready, 1);
    check("midrst_tx_valid", tx_valid, 0);
    // A write still present when reset is released counts as a new access.
    addrbus = 16'hFF00; rw = 1'b1; cpu_drv = 1'b1; cpu_dat = 8'h77;
    tick();
    rst = 1'b1;
    tick();
    idle();
    tick();
    check("postrst_tx_valid", tx_valid, 1);
    check("postrst_tx_data", tx_data, 8'h77);
    rd_chk("postrst_count", 16'hFF03, 1, 8'h01);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    rd_chk("postrst_count0", 16'hFF03, 1, 8'h00);
    rd_chk("postrst_rx_empty", 16'hFF01, 1, 8'h00);

    // Addresses just outside the window are ignored.
    rd_chk("below_hiz", 16'hFEFF, 1, 8'hFF);
    rd_chk("above_hiz", 16'hFF04, 1, 8'hFF);
    cpu_wr(16'hFEFF, 8'h33, 1);
    cpu_wr(16'hFF04, 8'h33, 1);
    rd_chk("outside_count", 16'hFF03, 1, 8'h00);
    check("outside_tx_valid", tx_valid, 0);
    rd_chk("txdata_reads_zero", 16'hFF00, 1, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
